fpro_mmio_arbiter: RTL

Two-master arbiter that shares the single FPro MMIO bus between the CPU-side master (m0) and a secondary master (m1), e.g. a DMA or debug bridge. It sits between the masters and the MMIO subsystem's `mmio_*` inputs. Each granted request becomes exactly one registered bus cycle. Read data is captured and returned with a one-cycle ack pulse.

---
 rtl/fpro_arb_pkg.sv | 25 ++
 rtl/fpro_arb_pick.sv | 35 +++
 rtl/fpro_mmio_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fpro_arb_pkg.sv
// Shared types and constants for the two-master FPro MMIO arbiter.
package fpro_arb_pkg;

  // Widths of the latched command; the arbiter's ADDR_W/DATA_W default to these.
  localparam int ARB_ADDR_W = 21;
  localparam int ARB_DATA_W = 32;

  // Master indices.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  wr;
    logic                  rd;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wr_data;
  } arb_cmd_t;

endpackage

// File: rtl/fpro_arb_pick.sv
// Combinational winner selection between two MMIO masters.
// Default: round-robin on a tie (the master that did not win last time).
// MMIO_ARB_FIXED_PRIO_EN defined: m0 always wins a tie and `last` is ignored.
module fpro_arb_pick
  import fpro_arb_pkg::*;
(
  input  logic m0_req,
  input  logic m1_req,
  input  logic last,
  output logic win_idx,
  output logic win_valid
);

  logic tie_idx;

`ifdef MMIO_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
  assign tie_idx     = M0;
`else
  assign tie_idx     = ~last;
`endif

  // Single requester wins outright; a tie goes to tie_idx.
  always_comb begin
    win_valid = m0_req | m1_req;
    win_idx   = M0;
    if (m0_req && m1_req) begin
      win_idx = tie_idx;
    end else if (m1_req) begin
      win_idx = M1;
    end
  end

endmodule

// File: rtl/fpro_mmio_arbiter.sv
// Two-master arbiter in front of the FPro MMIO subsystem.
// Each grant becomes one registered bus cycle (BUS) followed by a one-cycle
// ack pulse (ACK) carrying the captured read data.
// Optional macro: MMIO_ARB_FIXED_PRIO_EN selects fixed m0 priority on ties.
//
// Handshake: a master raises req with a stable command and keeps it until
// its ack pulse; the command is latched on the grant cycle, so later changes
// to req/command do not affect the transaction in flight.
module fpro_mmio_arbiter
  import fpro_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic              m0_rd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic              m1_rd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_ack,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data,
  output logic              busy,
  output logic              grant_id
);

  arb_state_t        state_q, state_d;
  arb_cmd_t          cmd_q, cmd_d;
  arb_cmd_t          sel_cmd;
  logic              last_q, last_d;
  logic              grant_q, grant_d;
  logic              cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m0_rd_data_q, m0_rd_data_d;
  logic [DATA_W-1:0] m1_rd_data_q, m1_rd_data_d;
  logic [DATA_W-1:0] cap_data;
  logic              win_idx, win_valid;

  fpro_arb_pick u_pick (
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .last      (last_q),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // Next-state, command latch, strobe and ack/read-data computation.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    last_d       = last_q;
    grant_d      = grant_q;
    cs_d         = 1'b0;
    wr_d         = 1'b0;
    rd_d         = 1'b0;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rd_data_d = m0_rd_data_q;
    m1_rd_data_d = m1_rd_data_q;
    cap_data     = '0;
    sel_cmd.wr      = m0_wr;
    sel_cmd.rd      = m0_rd;
    sel_cmd.addr    = ARB_ADDR_W'(m0_addr);
    sel_cmd.wr_data = ARB_DATA_W'(m0_wr_data);
    if (win_idx == M1) begin
      sel_cmd.wr      = m1_wr;
      sel_cmd.rd      = m1_rd;
      sel_cmd.addr    = ARB_ADDR_W'(m1_addr);
      sel_cmd.wr_data = ARB_DATA_W'(m1_wr_data);
    end
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_idx;
          last_d  = win_idx;
          cmd_d   = sel_cmd;
          // Write wins over read; a null command keeps the bus deselected.
          cs_d    = sel_cmd.wr | sel_cmd.rd;
          wr_d    = sel_cmd.wr;
          rd_d    = sel_cmd.rd & ~sel_cmd.wr;
          state_d = BUS;
        end
      end
      BUS: begin
        if (cmd_q.wr || cmd_q.rd) begin
          cap_data = mmio_rd_data;
        end
        if (grant_q == M1) begin
          m1_ack_d     = 1'b1;
          m1_rd_data_d = cap_data;
        end else begin
          m0_ack_d     = 1'b1;
          m0_rd_data_d = cap_data;
        end
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      last_q       <= M1;
      grant_q      <= M0;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rd_data_q <= '0;
      m1_rd_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      busy_q       <= busy_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rd_data_q <= m0_rd_data_d;
      m1_rd_data_q <= m1_rd_data_d;
    end
  end

  assign mmio_cs      = cs_q;
  assign mmio_wr      = wr_q;
  assign mmio_rd      = rd_q;
  assign mmio_addr    = ADDR_W'(cmd_q.addr);
  assign mmio_wr_data = DATA_W'(cmd_q.wr_data);
  assign m0_ack       = m0_ack_q;
  assign m1_ack       = m1_ack_q;
  assign m0_rd_data   = m0_rd_data_q;
  assign m1_rd_data   = m1_rd_data_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;

endmodule
